// File: rtl/chal_pkg.sv
// Shared constants, state encoding and LFSR step function for the
// challenge/response generator.
package chal_pkg;

  localparam int          W            = 64;
  localparam logic [63:0] LFSR_MASK    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    SEND = 2'd2
  } state_t;

  // One right-shift Galois step, taps x^64+x^63+x^61+x^60+1.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 64'h0);
  endfunction

endpackage

// File: rtl/chal_lfsr.sv
// 64-bit Galois LFSR used as the nonce source. Load restores the seed;
// enable advances one step. Exposes both the current and the next state.
module chal_lfsr
  import chal_pkg::*;
#(
  parameter logic [63:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  output logic [63:0] state,
  output logic [63:0] next
);

  // An all-zero seed would lock the register; substitute 1.
  localparam logic [63:0] SEED_NZ = (SEED == 64'h0) ? 64'h1 : SEED;

  assign next = lfsr_step(state);

  // State register: load has priority over advance.
  always_ff @(posedge clk) begin
    if (load)    state <= SEED_NZ;
    else if (en) state <= next;
  end

endmodule

// File: rtl/chal_resp_gen.sv
// Transmit-side challenge generator. On request with a valid key it steps
// the LFSR STEPS times, then offers nonce r_1 and masked c_2 = r_1 ^ k over
// a valid/ready handshake. Dropping done_i in GEN or SEND aborts.
// Optional: define CHAL_TIMEOUT_EN to abandon SEND after TIMEOUT cycles
// without ready_i, pulsing timeout_o.
module chal_resp_gen
  import chal_pkg::*;
#(
  parameter int          W         = chal_pkg::W,
  parameter logic [63:0] LFSR_SEED = DEFAULT_SEED,
  parameter int          STEPS     = 8,
  parameter int          CNT_W     = 16,
  parameter int          TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     k_i,
  input  logic             done_i,
  input  logic             start_i,
  input  logic             ready_i,
  output logic [W-1:0]     r_1_o,
  output logic [W-1:0]     c_2_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] nonce_cnt_o
`ifdef CHAL_TIMEOUT_EN
  ,
  output logic             timeout_o
`endif
);

  localparam logic [7:0] STEP_INIT = 8'(STEPS - 1);

  state_t             state_q, state_d;
  logic [7:0]         step_q, step_d;
  logic [W-1:0]       k_q, k_d;
  logic [W-1:0]       r_1_d, c_2_d;
  logic               valid_d, busy_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               lfsr_en;
  logic [63:0]        lfsr_cur, lfsr_nxt;

`ifdef CHAL_TIMEOUT_EN
  localparam int            WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_d;
`endif

  // Reload the seed on reset, and also if the register ever reads zero
  // (e.g. after an upset) so the sequence cannot lock up.
  chal_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .load  (rst || (lfsr_cur == 64'h0)),
    .en    (lfsr_en),
    .state (lfsr_cur),
    .next  (lfsr_nxt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and next-output logic. Priority in SEND: abort, transfer,
  // then timeout.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    k_d     = k_q;
    r_1_d   = r_1_o;
    c_2_d   = c_2_o;
    valid_d = 1'b0;
    cnt_d   = nonce_cnt_o;
    lfsr_en = 1'b0;
`ifdef CHAL_TIMEOUT_EN
    wait_d    = wait_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && done_i) begin
          k_d     = k_i;
          step_d  = STEP_INIT;
          state_d = GEN;
        end
      end
      GEN: begin
        lfsr_en = 1'b1;
        if (!done_i) begin
          state_d = IDLE;
        end else if (step_q == 8'd0) begin
          r_1_d   = lfsr_nxt;
          c_2_d   = lfsr_nxt ^ k_q;
          valid_d = 1'b1;
          state_d = SEND;
`ifdef CHAL_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          step_d = step_q - 8'd1;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        if (!done_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (ready_i) begin
          valid_d = 1'b0;
          cnt_d   = nonce_cnt_o + CNT_W'(1);
          state_d = IDLE;
        end
`ifdef CHAL_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= '0;
      k_q         <= '0;
      r_1_o       <= '0;
      c_2_o       <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      nonce_cnt_o <= '0;
    end else begin
      step_q      <= step_d;
      k_q         <= k_d;
      r_1_o       <= r_1_d;
      c_2_o       <= c_2_d;
      valid_o     <= valid_d;
      busy_o      <= busy_d;
      nonce_cnt_o <= cnt_d;
    end
  end

`ifdef CHAL_TIMEOUT_EN
  // SEND wait counter and one-cycle timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= '0;
      timeout_o <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_o <= timeout_d;
    end
  end
`endif

endmodule
